run_mode_controller: RTL



---
 rtl/run_mode_pkg.sv | 37 +++
 rtl/cycle_timer.sv | 31 +++
 rtl/run_mode_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/run_mode_pkg.sv
// Shared state type, LED mapping and default dwell constants for run_mode_controller.
package run_mode_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArming  = 2'd1,
      StRun     = 2'd2,
      StBraking = 2'd3
   } run_state_t;

   localparam logic [1:0] LED_IDLE    = 2'd0;
   localparam logic [1:0] LED_ARMING  = 2'd1;
   localparam logic [1:0] LED_RUN     = 2'd2;
   localparam logic [1:0] LED_BRAKING = 2'd3;

   localparam int unsigned ARM_CYCLES_DEF   = 125_000_000;
   localparam int unsigned BRAKE_CYCLES_DEF = 62_500_000;
   localparam int unsigned WDT_CYCLES_DEF   = 12_500_000;

   // Bits needed to hold counts 0 .. max_count-1.
   function automatic int unsigned cnt_width(input int unsigned max_count);
      return (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

   function automatic logic [1:0] state_led(input run_state_t s);
      logic [1:0] led;
      led = LED_IDLE;
      unique case (s)
         StIdle:    led = LED_IDLE;
         StArming:  led = LED_ARMING;
         StRun:     led = LED_RUN;
         StBraking: led = LED_BRAKING;
      endcase
      return led;
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that holds at zero; o_done flags a zero count.
module cycle_timer
   import run_mode_pkg::*;
#(
   parameter int unsigned  MAX_COUNT = 8,
   localparam int unsigned W         = cnt_width(MAX_COUNT)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic [W-1:0] o_value,
   output logic         o_done
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_value = r_count;
   assign o_done  = (r_count == '0);

endmodule

// File: rtl/run_mode_controller.sv
// Operator run/stop sequencer and setpoint register for the PID wall follower.
// Define WATCHDOG_EN to add the sensor-strobe watchdog and the sticky fault flag.
module run_mode_controller
   import run_mode_pkg::*;
#(
   parameter int unsigned     SP_W         = 12,
   parameter logic [SP_W-1:0] SP_RESET     = 12'd400,
   parameter logic [SP_W-1:0] SP_STEP      = 12'd10,
   parameter logic [SP_W-1:0] SP_MIN       = 12'd100,
   parameter logic [SP_W-1:0] SP_MAX       = 12'd2000,
   parameter int unsigned     ARM_CYCLES   = ARM_CYCLES_DEF,
   parameter int unsigned     BRAKE_CYCLES = BRAKE_CYCLES_DEF,
   parameter int unsigned     WDT_CYCLES   = WDT_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start_pb,
   input  logic            stop_pb,
   input  logic            up_pb,
   input  logic            down_pb,
   input  logic            sensor_valid,
   output logic            run_en,
   output logic            brake,
   output logic            pid_clear,
   output logic [SP_W-1:0] setpoint,
   output logic [1:0]      state_o,
   output logic            fault
);

   localparam int unsigned TMR_MAX = (ARM_CYCLES > BRAKE_CYCLES) ? ARM_CYCLES : BRAKE_CYCLES;
   localparam int unsigned TMR_W   = cnt_width(TMR_MAX);
   localparam logic [TMR_W-1:0] ARM_LOAD   = TMR_W'(ARM_CYCLES - 1);
   localparam logic [TMR_W-1:0] BRAKE_LOAD = TMR_W'(BRAKE_CYCLES - 1);

   run_state_t       r_state;
   logic             r_run_en;
   logic             r_brake;
   logic             r_pid_clear;
   logic             r_fault;
   logic [SP_W-1:0]  r_setpoint;
   logic [SP_W-1:0]  w_sp_next;
   logic [SP_W:0]    w_sp_ext;
   logic [SP_W:0]    w_sp_inc;
   logic [SP_W:0]    w_sp_floor;
   logic             w_sp_adj_ok;
   logic             w_start_ok;
   logic             w_wdt_trip;
   logic             w_tmr_load;
   logic             w_tmr_done;
   logic [TMR_W-1:0] w_tmr_val;
   logic [TMR_W-1:0] w_tmr_value;
   logic             w_unused_tmr;

   assign w_start_ok = (r_state == StIdle) && start_pb && !stop_pb;
   assign w_tmr_load = w_start_ok || ((r_state == StRun) && (stop_pb || w_wdt_trip));
   assign w_tmr_val  = (r_state == StIdle) ? ARM_LOAD : BRAKE_LOAD;

   cycle_timer #(
      .MAX_COUNT (TMR_MAX)
   ) u_dwell_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_tmr_load),
      .i_value (w_tmr_val),
      .o_value (w_tmr_value),
      .o_done  (w_tmr_done)
   );

   assign w_unused_tmr = ^w_tmr_value;

`ifdef WATCHDOG_EN
   localparam int unsigned WDT_W = cnt_width(WDT_CYCLES);
   localparam logic [WDT_W-1:0] WDT_LOAD = WDT_W'(WDT_CYCLES - 1);

   logic             w_wdt_load;
   logic             w_wdt_done;
   logic [WDT_W-1:0] w_wdt_value;
   logic             w_unused_wdt;

   // Reload on RUN entry and on every sensor strobe while running.
   assign w_wdt_load = ((r_state == StArming) && w_tmr_done && !stop_pb) ||
                       ((r_state == StRun) && sensor_valid);
   assign w_wdt_trip = (r_state == StRun) && w_wdt_done && !sensor_valid;

   cycle_timer #(
      .MAX_COUNT (WDT_CYCLES)
   ) u_wdt_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_wdt_load),
      .i_value (WDT_LOAD),
      .o_value (w_wdt_value),
      .o_done  (w_wdt_done)
   );

   assign w_unused_wdt = ^w_wdt_value;
`else
   logic w_unused_wdt;

   assign w_wdt_trip   = 1'b0;
   assign w_unused_wdt = sensor_valid ^ (WDT_CYCLES == 0);
`endif

   // Extra top bit keeps the step arithmetic free of wrap-around.
   assign w_sp_adj_ok = (r_state == StIdle) || (r_state == StRun);
   assign w_sp_ext    = {1'b0, r_setpoint};
   assign w_sp_inc    = w_sp_ext + {1'b0, SP_STEP};
   assign w_sp_floor  = {1'b0, SP_MIN} + {1'b0, SP_STEP};

   always_comb begin
      w_sp_next = r_setpoint;
      if (w_sp_adj_ok && (up_pb ^ down_pb)) begin
         if (up_pb) begin
            w_sp_next = (w_sp_inc > {1'b0, SP_MAX}) ? SP_MAX : w_sp_inc[SP_W-1:0];
         end else begin
            w_sp_next = (w_sp_ext < w_sp_floor) ? SP_MIN : (r_setpoint - SP_STEP);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_run_en    <= 1'b0;
         r_brake     <= 1'b0;
         r_pid_clear <= 1'b0;
         r_fault     <= 1'b0;
         r_setpoint  <= SP_RESET;
      end else begin
         r_setpoint  <= w_sp_next;
         r_pid_clear <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_start_ok) begin
                  r_state <= StArming;
                  r_fault <= 1'b0;
               end
            end
            StArming: begin
               if (stop_pb) begin
                  r_state <= StIdle;
               end else if (w_tmr_done) begin
                  r_state     <= StRun;
                  r_run_en    <= 1'b1;
                  r_pid_clear <= 1'b1;
               end
            end
            StRun: begin
               if (stop_pb || w_wdt_trip) begin
                  r_state  <= StBraking;
                  r_run_en <= 1'b0;
                  r_brake  <= 1'b1;
                  if (w_wdt_trip) r_fault <= 1'b1;
               end
            end
            StBraking: begin
               if (w_tmr_done) begin
                  r_state <= StIdle;
                  r_brake <= 1'b0;
               end
            end
         endcase
      end
   end

   assign run_en    = r_run_en;
   assign brake     = r_brake;
   assign pid_clear = r_pid_clear;
   assign fault     = r_fault;
   assign setpoint  = r_setpoint;
   assign state_o   = state_led(r_state);

endmodule
